sseg_capture: RTL

- Reader for the multiplexed seven-segment bus (sseg/an) that the display driver produces.
- Watches the active-low anode scan and samples the segment lines once each digit has settled. It decodes each pattern back to the 4-bit display code and reassembles the 16-bit display word.
- Used as an on-chip monitor and as the checking end in display-path testbenches. It lets the reaction-timer result be read back as data.

---
 rtl/sseg_pkg.sv | 50 +++++
 rtl/sseg_glyph_decode.sv | 43 ++++
 rtl/sseg_capture.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared constants for the seven-segment bus reader.
// Contents:
//   - segment bit positions inside the 8-bit sseg bus
//   - active-low glyph table for the codes the display driver emits
//   - special display codes (blank, invalid)
//   - scan-tracking FSM state type and state constants
// -----------------------------------------------------------------------------
package sseg_pkg;

    // Bit positions on the sseg bus: [7]=dp, [6:0]={g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Special display codes
    localparam logic [3:0] CODE_BLANK   = 4'hB;
    localparam logic [3:0] CODE_C       = 4'hC;
    localparam logic [3:0] CODE_E       = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; a 0 bit is a lit segment
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_E     = 7'h06;

    // Scan-tracking FSM
    typedef logic [1:0] scan_state_t;
    localparam scan_state_t ST_IDLE   = 2'd0;
    localparam scan_state_t ST_SETTLE = 2'd1;
    localparam scan_state_t ST_HOLD   = 2'd2;
    localparam scan_state_t ST_COMMIT = 2'd3;

endpackage

// File: rtl/sseg_glyph_decode.sv
// -----------------------------------------------------------------------------
// sseg_glyph_decode
// Purely combinational map from an active-low 7-segment pattern back to the
// 4-bit display code. Unknown patterns return CODE_INVALID with valid=0.
// Ports:
//   seg_n  in  7  active-low segments {g,f,e,d,c,b,a}
//   code   out 4  decoded display code
//   valid  out 1  1 when the pattern is a known glyph
// -----------------------------------------------------------------------------
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       valid
);

    // Table lookup of the glyph pattern
    always_comb begin
        code  = CODE_INVALID;
        valid = 1'b1;
        case (seg_n)
            GLYPH_0:     code = 4'h0;
            GLYPH_1:     code = 4'h1;
            GLYPH_2:     code = 4'h2;
            GLYPH_3:     code = 4'h3;
            GLYPH_4:     code = 4'h4;
            GLYPH_5:     code = 4'h5;
            GLYPH_6:     code = 4'h6;
            GLYPH_7:     code = 4'h7;
            GLYPH_8:     code = 4'h8;
            GLYPH_9:     code = 4'h9;
            GLYPH_BLANK: code = CODE_BLANK;
            GLYPH_C:     code = CODE_C;
            GLYPH_E:     code = CODE_E;
            default: begin
                code  = CODE_INVALID;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sseg_capture.sv
// -----------------------------------------------------------------------------
// sseg_capture
// Reader for a multiplexed seven-segment bus. Tracks the active-low anode
// scan, samples each digit once its anode has been stable for SETTLE_CYCLES,
// decodes the glyph and reassembles the display word once every digit has
// been seen.
// Ports:
//   clk           in  1   system clock
//   clear         in  1   asynchronous active-high reset
//   sseg          in  8   active-low segments, [7]=dp, [6:0]={g,f,e,d,c,b,a}
//   an            in  8   active-low anodes, only [N_DIGITS-1:0] legal
//   word          out 16  last complete decoded word, digit i in [4i+3:4i]
//   dp            out 4   last complete decimal points, 1 = lit
//   frame_valid   out 1   one-cycle pulse when word/dp update
//   word_changed  out 1   pulse with frame_valid when the word differs
//                         (or on the first frame after reset)
//   glyph_err     out 1   sticky: undecodable glyph captured
//   anode_err     out 1   sticky: illegal anode pattern seen
//   stale         out 1   no complete frame within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int N_DIGITS       = 4
)(
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  sseg,
    input  logic [7:0]  an,
    output logic [15:0] word,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        word_changed,
    output logic        glyph_err,
    output logic        anode_err,
    output logic        stale
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    // Counter value in the cycle before it reaches TMO_LAST
    localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(TIMEOUT_CYCLES - 2);

    // Input stage
    logic [7:0]                 sseg_q_r;
    logic [7:0]                 an_q_r;
    logic [7:0]                 an_prev_r;

    // Scan tracking
    scan_state_t                state_r;
    scan_state_t                state_nxt_s;
    logic [CNT_W-1:0]           cnt_r;
    logic [CNT_W-1:0]           cnt_nxt_s;
    logic                       capture_s;

    // Anode classification
    logic [3:0]                 low_cnt_s;
    logic [IDX_W-1:0]           low_idx_s;
    logic                       high_ok_s;
    logic                       blank_s;
    logic                       legal_s;
    logic                       illegal_s;
    logic                       changed_s;

    // Frame assembly
    logic [N_DIGITS-1:0][3:0]   slot_code_r;
    logic [N_DIGITS-1:0]        slot_dp_r;
    logic [N_DIGITS-1:0]        mask_r;
    logic [N_DIGITS-1:0]        cap_bits_s;
    logic                       mask_full_s;
    logic [15:0]                word_asm_s;
    logic [3:0]                 dp_asm_s;

    // Decoder
    logic [3:0]                 dec_code_s;
    logic                       dec_valid_s;

    // Timeout and outputs
    logic [TMO_W-1:0]           tmo_cnt_r;
    logic                       tmo_hit_s;
    logic                       first_r;
    logic [15:0]                word_r;
    logic [3:0]                 dp_r;
    logic                       frame_valid_r;
    logic                       word_changed_r;
    logic                       glyph_err_r;
    logic                       anode_err_r;
    logic                       stale_r;

    sseg_glyph_decode u_decode (
        .seg_n (sseg_q_r[6:0]),
        .code  (dec_code_s),
        .valid (dec_valid_s)
    );

    // Register the raw buses once; all decisions use the registered copies.
    // The anode/segment registers reset to all-high (nothing driven) so the
    // first cycle after reset is not mistaken for an all-anodes-low error.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sseg_q_r  <= 8'hFF;
            an_q_r    <= 8'hFF;
            an_prev_r <= 8'hFF;
        end else begin
            sseg_q_r  <= sseg;
            an_q_r    <= an;
            an_prev_r <= an_q_r;
        end
    end

    // Classify the registered anode bus and locate the low digit
    always_comb begin
        low_cnt_s = 4'd0;
        low_idx_s = {IDX_W{1'b0}};
        high_ok_s = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (an_q_r[i] == 1'b0) begin
                low_cnt_s = low_cnt_s + 4'd1;
                low_idx_s = IDX_W'(i);
            end else begin
                low_cnt_s = low_cnt_s;
            end
        end
        for (int i = N_DIGITS; i < 8; i++) begin
            if (an_q_r[i] == 1'b0) begin
                high_ok_s = 1'b0;
            end else begin
                high_ok_s = high_ok_s;
            end
        end
        blank_s   = &an_q_r;
        legal_s   = high_ok_s && (low_cnt_s == 4'd1);
        illegal_s = !blank_s && !legal_s;
        changed_s = (an_q_r != an_prev_r);
    end

    // Completion is detected from the mask alone: it is only full in the
    // cycle right after the capture that filled it.
    assign mask_full_s = &mask_r;

    // Scan FSM next state and dwell counter; capture fires once per dwell
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (legal_s) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!legal_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (changed_s) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HOLD;
                    capture_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD, ST_COMMIT: begin
                if (!legal_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (changed_s) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if ((state_r == ST_HOLD) && mask_full_s) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Scan FSM state and dwell counter registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Mask bit for the digit being captured and the assembled word/dp
    always_comb begin
        cap_bits_s = {N_DIGITS{1'b0}};
        if (capture_s) begin
            cap_bits_s[low_idx_s] = 1'b1;
        end else begin
            cap_bits_s = {N_DIGITS{1'b0}};
        end
        word_asm_s = 16'h0000;
        dp_asm_s   = 4'b0000;
        for (int i = 0; i < N_DIGITS; i++) begin
            word_asm_s[4*i +: 4] = slot_code_r[i];
            dp_asm_s[i]          = slot_dp_r[i];
        end
    end

    // A timeout only takes effect when no frame completes in the same cycle
    assign tmo_hit_s = !mask_full_s && (tmo_cnt_r == TMO_HIT);

    // Digit slots; a recapture before completion simply overwrites the slot
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            slot_code_r <= {N_DIGITS{4'h0}};
            slot_dp_r   <= {N_DIGITS{1'b0}};
        end else if (capture_s) begin
            slot_code_r[low_idx_s] <= dec_code_s;
            slot_dp_r[low_idx_s]   <= ~sseg_q_r[SEG_DP];
        end else begin
            slot_code_r <= slot_code_r;
            slot_dp_r   <= slot_dp_r;
        end
    end

    // Capture mask: cleared by completion or timeout, a same-cycle capture
    // survives a timeout so the digit is not lost
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mask_r <= {N_DIGITS{1'b0}};
        end else if (mask_full_s) begin
            mask_r <= {N_DIGITS{1'b0}};
        end else if (tmo_hit_s) begin
            mask_r <= cap_bits_s;
        end else begin
            mask_r <= mask_r | cap_bits_s;
        end
    end

    // Frame commit, change detection, timeout and stale flag
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            word_r         <= 16'h0000;
            dp_r           <= 4'b0000;
            frame_valid_r  <= 1'b0;
            word_changed_r <= 1'b0;
            first_r        <= 1'b1;
            stale_r        <= 1'b0;
            tmo_cnt_r      <= {TMO_W{1'b0}};
        end else if (mask_full_s) begin
            word_r         <= word_asm_s;
            dp_r           <= dp_asm_s;
            frame_valid_r  <= 1'b1;
            word_changed_r <= first_r | (word_asm_s != word_r);
            first_r        <= 1'b0;
            stale_r        <= 1'b0;
            tmo_cnt_r      <= {TMO_W{1'b0}};
        end else begin
            frame_valid_r  <= 1'b0;
            word_changed_r <= 1'b0;
            stale_r        <= stale_r | tmo_hit_s;
            if (tmo_cnt_r != TMO_LAST) begin
                tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            glyph_err_r <= 1'b0;
            anode_err_r <= 1'b0;
        end else begin
            glyph_err_r <= glyph_err_r | (capture_s & ~dec_valid_s);
            anode_err_r <= anode_err_r | illegal_s;
        end
    end

    assign word         = word_r;
    assign dp           = dp_r;
    assign frame_valid  = frame_valid_r;
    assign word_changed = word_changed_r;
    assign glyph_err    = glyph_err_r;
    assign anode_err    = anode_err_r;
    assign stale        = stale_r;

endmodule
